// File: rtl/divisor_restador_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : divisor_restador_ctrl_if
// Description : Handshake/data bundle for the restoring divider: start
//               request with operands in, registered results and status out.
// Revision    : 1.0 - initial release
// ============================================================================
interface divisor_restador_ctrl_if;
  logic       start;
  logic [7:0] dividendo;
  logic [7:0] divisor;
  logic [7:0] cociente;
  logic [7:0] residuo;
  logic       busy;
  logic       done;
  logic       div0;

  // Divider side
  modport slave (
    input  start, dividendo, divisor,
    output cociente, residuo, busy, done, div0
  );

  // Requester side
  modport master (
    output start, dividendo, divisor,
    input  cociente, residuo, busy, done, div0
  );
endinterface
`default_nettype wire

// File: rtl/divisor_restador_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : divisor_restador_ctrl
// Description : 8-bit unsigned restoring divider, one quotient bit per clock.
//               IDLE -> RUN (8 cycles) -> DONE (1 cycle) -> IDLE.
//               Optional macro DIV0_DETECT_EN: a zero divisor skips RUN and
//               reports DIV0 with quotient 8'hFF, remainder = dividend.
// Revision    : 1.0 - initial release
// ============================================================================
module divisor_restador_ctrl (
  input  wire logic                    clk,
  input  wire logic                    rst,
  divisor_restador_ctrl_if.slave       bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic [7:0] r_dvd;       // dividend, shifted out MSB first
  logic [7:0] r_dsr;       // latched divisor
  logic [7:0] r_rem;       // partial remainder (always < divisor, fits 8 bits)
  logic [7:0] r_quot;      // quotient bits collected so far
  logic [3:0] r_cnt;       // iteration counter
  logic [7:0] r_cociente;
  logic [7:0] r_residuo;

  logic [8:0] w_shift;     // 9-bit shifted partial remainder
  logic [8:0] w_trial;     // shifted remainder minus divisor
  logic       w_qbit;
  logic [7:0] w_rem_nxt;
  logic       w_accept;
  logic       w_last;
  logic       w_zero_div;

  assign w_accept = (r_state == S_IDLE) && bus.start;
  assign w_last   = (r_cnt == 4'd7);

`ifdef DIV0_DETECT_EN
  logic r_div0;
  assign w_zero_div = (bus.divisor == 8'd0);
  assign bus.div0   = r_div0;
`else
  assign w_zero_div = 1'b0;
  assign bus.div0   = 1'b0;
`endif

  // One restoring step: subtract by adding the 9-bit two's complement,
  // keep the trial only when it did not go negative.
  always_comb begin
    w_shift   = {r_rem, r_dvd[7]};
    w_trial   = w_shift + (~{1'b0, r_dsr} + 9'd1);
    w_qbit    = ~w_trial[8];
    w_rem_nxt = w_qbit ? w_trial[7:0] : w_shift[7:0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = w_zero_div ? S_DONE : S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand latch, iteration datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dvd      <= 8'd0;
      r_dsr      <= 8'd0;
      r_rem      <= 8'd0;
      r_quot     <= 8'd0;
      r_cnt      <= 4'd0;
      r_cociente <= 8'd0;
      r_residuo  <= 8'd0;
`ifdef DIV0_DETECT_EN
      r_div0     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_dvd  <= bus.dividendo;
            r_dsr  <= bus.divisor;
            r_rem  <= 8'd0;
            r_quot <= 8'd0;
            r_cnt  <= 4'd0;
`ifdef DIV0_DETECT_EN
            r_div0 <= 1'b0;
            if (w_zero_div) begin
              r_cociente <= 8'hFF;
              r_residuo  <= bus.dividendo;
              r_div0     <= 1'b1;
            end
`endif
          end
        end
        S_RUN: begin
          r_dvd  <= {r_dvd[6:0], 1'b0};
          r_rem  <= w_rem_nxt;
          r_quot <= {r_quot[6:0], w_qbit};
          r_cnt  <= r_cnt + 4'd1;
          if (w_last) begin
            r_cociente <= {r_quot[6:0], w_qbit};
            r_residuo  <= w_rem_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cociente = r_cociente;
  assign bus.residuo  = r_residuo;
  assign bus.busy     = (r_state == S_RUN) || (r_state == S_DONE);
  assign bus.done     = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_divisor_restador_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_divisor_restador_ctrl
// Description : Self-checking bench for divisor_restador_ctrl. Expected
//               results are queued when a division is launched and compared
//               when DONE is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divisor_restador_ctrl;

  logic clk = 1'b0;
  logic rst;

  divisor_restador_ctrl_if bus ();

  divisor_restador_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    int r;
    int d0;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   errs   = 0;
  int   checks = 0;

  // Single comparison point
  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference model: push expected outcome for a/b
  task automatic push_exp(input int a, input int b);
    exp_t e;
    if (b == 0) begin
      e.q = 255;
      e.r = a;
`ifdef DIV0_DETECT_EN
      e.d0  = 1;
      e.lat = 1;
`else
      e.d0  = 0;
      e.lat = 8;
`endif
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.d0  = 0;
      e.lat = 8;
    end
    sb.push_back(e);
  endtask

  // Called #1 after the accepting edge; waits for DONE, compares, then
  // checks the pulse is one cycle wide.
  task automatic wait_and_check(input string tag);
    int   n   = 0;
    bit   got = 0;
    exp_t e;
    while (n < 40 && !got) begin
      @(posedge clk); #1;
      n++;
      if (bus.done) got = 1;
    end
    e = sb.pop_front();
    if (!got) begin
      check({tag, "_timeout"}, 0, 1);
    end else begin
      check({tag, "_lat"}, n, e.lat);
      check({tag, "_q"},   int'(bus.cociente), e.q);
      check({tag, "_r"},   int'(bus.residuo),  e.r);
      check({tag, "_d0"},  int'(bus.div0),     e.d0);
      check({tag, "_busy"}, int'(bus.busy),    1);
      @(posedge clk); #1;
      check({tag, "_pulse"}, int'(bus.done), 0);
    end
  endtask

  task automatic run_div(input string tag, input int a, input int b);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.dividendo = 8'(a);
    bus.divisor   = 8'(b);
    push_exp(a, b);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, "_busy_acc"}, int'(bus.busy), 1);
    wait_and_check(tag);
  endtask

  initial begin
    int ndone;
    int a, b;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.dividendo = 8'd0;
    bus.divisor   = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_q",    int'(bus.cociente), 0);
    check("rst_r",    int'(bus.residuo),  0);
    check("rst_busy", int'(bus.busy),     0);
    check("rst_done", int'(bus.done),     0);
    check("rst_d0",   int'(bus.div0),     0);

    // START accepted on first edge with reset released: 200/7
    @(negedge clk);
    rst           = 1'b0;
    bus.start     = 1'b1;
    bus.dividendo = 8'd200;
    bus.divisor   = 8'd7;
    push_exp(200, 7);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("d200_7_busy_acc", int'(bus.busy), 1);
    wait_and_check("d200_7");

    // Boundaries
    run_div("d255_1",   255, 1);
    run_div("d5_9",     5,   9);
    run_div("d255_255", 255, 255);
    run_div("d0_3",     0,   3);
    run_div("d100_0",   100, 0);

    // START held high, operands changed mid-RUN
    @(negedge clk);
    bus.start     = 1'b1;
    bus.dividendo = 8'd50;
    bus.divisor   = 8'd6;
    push_exp(50, 6);
    push_exp(77, 5);
    @(posedge clk); #1;
    bus.dividendo = 8'd77;
    bus.divisor   = 8'd5;
    wait_and_check("hold1");
    // DONE->IDLE at the previous edge; still-high START accepted now
    check("hold_idle_busy", int'(bus.busy), 0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("hold2_busy_acc", int'(bus.busy), 1);
    wait_and_check("hold2");

    // Reset during the 4th RUN cycle of 200/7
    @(negedge clk);
    bus.start     = 1'b1;
    bus.dividendo = 8'd200;
    bus.divisor   = 8'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_q",    int'(bus.cociente), 0);
    check("abort_r",    int'(bus.residuo),  0);
    check("abort_busy", int'(bus.busy),     0);
    check("abort_done", int'(bus.done),     0);
    check("abort_d0",   int'(bus.div0),     0);
    @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    check("abort_nodone", ndone, 0);
    run_div("d9_2", 9, 2);

    // Random operand pairs
    for (int i = 0; i < 1000; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      run_div("rnd", a, b);
    end

    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/divisor_restador_ctrl.md
DIVISOR_RESTADOR_CTRL -- requirements
Module: divisor_restador_ctrl

Interface
REQ-001 SHALL have no parameters; datapath width fixed at 8 bits unsigned.
REQ-002 SHALL have port CLK, input, 1, single clock; all state changes on rising edge.
REQ-003 SHALL have port RST, input, 1, reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port START, input, 1, request to begin one division; sampled only in IDLE.
REQ-005 SHALL have port DIVIDENDO, input, 8, dividend; latched on accepted START.
REQ-006 SHALL have port DIVISOR, input, 8, divisor; latched on accepted START.
REQ-007 SHALL have port COCIENTE, output, 8, quotient; registered.
REQ-008 SHALL have port RESIDUO, output, 8, remainder; registered.
REQ-009 SHALL have port BUSY, output, 1, high in RUN and DONE states.
REQ-010 SHALL have port DONE, output, 1, single-cycle pulse marking COCIENTE/RESIDUO valid.
REQ-011 SHALL have port DIV0, output, 1, divide-by-zero flag; valid with DONE, held until next accepted START.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; encoding free.
REQ-013 SHALL, in IDLE with START=1 at an edge, latch operands, clear 9-bit partial remainder, clear 4-bit iteration counter, clear DIV0, enter RUN.
REQ-014 SHALL ignore START in RUN and DONE; latched operands unaffected.
REQ-015 SHALL, per RUN cycle, shift {remainder, dividend MSB} left one bit, compute trial = shifted remainder minus zero-extended divisor by adding the 9-bit two's complement of the divisor.
REQ-016 SHALL, if trial non-negative (bit 8 clear), keep trial and shift 1 into quotient LSB; else keep shifted remainder and shift 0 in (restoring division).
REQ-017 SHALL perform exactly 8 RUN iterations, MSB first; after the 8th edge enter DONE.
REQ-018 SHALL update COCIENTE/RESIDUO only on the edge entering DONE; held stable until next entry into DONE or reset.
REQ-019 SHALL assert DONE for exactly one cycle while in DONE, then return unconditionally to IDLE.
REQ-020 SHALL give latency: START accepted at edge k -> DONE high in the cycle following edge k+8; throughput one division per 10 cycles.
REQ-021 SHALL assert BUSY from the cycle after the accepting edge through the DONE cycle inclusive.
REQ-022 SHALL satisfy DIVIDENDO = COCIENTE*DIVISOR + RESIDUO with RESIDUO < DIVISOR for all DIVISOR != 0.
REQ-023 SHALL treat DIVIDENDO=0 as normal: COCIENTE=0, RESIDUO=0, full latency.

Reset
REQ-024 SHALL, with RST=1 at an edge, enter IDLE; COCIENTE=0, RESIDUO=0, BUSY=0, DONE=0, DIV0=0; counter and partial remainder cleared.
REQ-025 SHALL give RST priority over START and over any state, including mid-RUN; no DONE pulse for an aborted division.
REQ-026 SHALL accept START on the first edge with RST=0.

Configuration
REQ-027 SHALL use macro DIV0_DETECT_EN for divide-by-zero detection.
REQ-028 SHALL, with DIV0_DETECT_EN defined and DIVISOR=0 at accepted START, skip RUN and enter DONE on the next edge with COCIENTE=8'hFF, RESIDUO=DIVIDENDO, DIV0=1.
REQ-029 SHALL, without DIV0_DETECT_EN, tie DIV0 to 0 and run DIVISOR=0 through the normal 8-iteration path (yields COCIENTE=8'hFF, RESIDUO=DIVIDENDO).

Verification
REQ-030 SHALL cover 200/7: START pulse -> DONE 9 cycles after accepting edge, COCIENTE=28, RESIDUO=4, DIV0=0.
REQ-031 SHALL cover boundaries 255/1 -> 255 r0; 5/9 -> 0 r5; 255/255 -> 1 r0; 0/3 -> 0 r0.
REQ-032 SHALL cover 100/0: with DIV0_DETECT_EN -> DONE one cycle after accept, COCIENTE=255, RESIDUO=100, DIV0=1; without -> same values after 9 cycles, DIV0=0.
REQ-033 SHALL cover START held high continuously with changing operands mid-RUN -> result uses operands from accepting edge; next division starts from IDLE after DONE.
REQ-034 SHALL cover RST=1 at 4th RUN cycle of 200/7 -> IDLE, all outputs 0, no DONE; subsequent 9/2 -> 4 r1.
REQ-035 SHALL cover random self-check of 1000 operand pairs against REQ-022.
